// File: rtl/lsu_arbiter_pkg.sv
// Shared definitions for the LSU arbiter: requester identity and default depth.
package lsu_arbiter_pkg;

    // Requester identity; port 0 carries the older instruction.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    // Default number of accepted-but-unanswered requests tracked.
    localparam int OUTST_DEPTH_DEF = 4;

endpackage : lsu_arbiter_pkg

// File: rtl/lsu_arbiter_order_fifo.sv
// In-order FIFO of requester ids: records who owns each outstanding request
// so responses, which return in order, can be steered back to the right port.
module order_fifo
    import lsu_arbiter_pkg::*;
#(
    parameter int DEPTH = OUTST_DEPTH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  port_id_e push_id,
    input  logic     pop,
    output port_id_e head_id,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and head entry decoded from the registered state.
    always_comb begin
        full    = (cnt_q == CNT_W'(DEPTH));
        empty   = (cnt_q == {CNT_W{1'b0}});
        head_id = port_id_e'(mem_q[rd_ptr_q]);
    end

    // Next-state: guarded push/pop; pointers wrap naturally (depth is a power of two).
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State register with synchronous reset that discards all entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule : order_fifo

// File: rtl/lsu_arbiter.sv
// Two-requester LSU arbiter onto a single MMU channel: fixed priority to
// port 0, grant held until address handshake, in-order response steering.
module lsu_arbiter
    import lsu_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = OUTST_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_req,
    input  logic [31:0] s0_addr,
    input  logic        s0_we,
    input  logic [1:0]  s0_size,
    input  logic [3:0]  s0_wstrb,
    input  logic [31:0] s0_wdata,
    output logic        s0_addr_ok,
    output logic        s0_data_ok,
    output logic [31:0] s0_rdata,
    output logic        s0_tlbr,
    output logic        s0_pil,
    output logic        s0_pis,
    output logic        s0_ppi,
    output logic        s0_pme,
    input  logic        s1_req,
    input  logic [31:0] s1_addr,
    input  logic        s1_we,
    input  logic [1:0]  s1_size,
    input  logic [3:0]  s1_wstrb,
    input  logic [31:0] s1_wdata,
    output logic        s1_addr_ok,
    output logic        s1_data_ok,
    output logic [31:0] s1_rdata,
    output logic        s1_tlbr,
    output logic        s1_pil,
    output logic        s1_pis,
    output logic        s1_ppi,
    output logic        s1_pme,
    output logic        mmu_req,
    output logic [31:0] mmu_addr,
    output logic        mmu_we,
    output logic [1:0]  mmu_size,
    output logic [3:0]  mmu_wstrb,
    output logic [31:0] mmu_wdata,
    input  logic        mmu_addr_ok,
    input  logic        mmu_data_ok,
    input  logic [31:0] mmu_rdata,
    input  logic        mmu_tlbr,
    input  logic        mmu_pil,
    input  logic        mmu_pis,
    input  logic        mmu_ppi,
    input  logic        mmu_pme
);

    logic     lock_valid_q, lock_valid_d;
    port_id_e lock_port_q, lock_port_d;
    port_id_e sel_s;
    logic     sel_req_s;
    logic     push_s;
    logic     pop_s;
    port_id_e head_s;
    logic     fifo_full_s;
    logic     fifo_empty_s;
    logic     grant0_s;
    logic     grant1_s;

    // Port selection: a pending locked request wins, otherwise fixed priority.
    always_comb begin
        sel_s = PORT1;
        if (lock_valid_q) begin
            sel_s = lock_port_q;
        end else if (s0_req) begin
            sel_s = PORT0;
        end else begin
            sel_s = PORT1;
        end
    end

    // Request channel mux; issue is throttled when every order slot is in use.
    always_comb begin
        sel_req_s = 1'b0;
        mmu_addr  = 32'h0000_0000;
        mmu_we    = 1'b0;
        mmu_size  = 2'b00;
        mmu_wstrb = 4'h0;
        mmu_wdata = 32'h0000_0000;
        case (sel_s)
            PORT0: begin
                sel_req_s = s0_req;
                mmu_addr  = s0_addr;
                mmu_we    = s0_we;
                mmu_size  = s0_size;
                mmu_wstrb = s0_wstrb;
                mmu_wdata = s0_wdata;
            end
            PORT1: begin
                sel_req_s = s1_req;
                mmu_addr  = s1_addr;
                mmu_we    = s1_we;
                mmu_size  = s1_size;
                mmu_wstrb = s1_wstrb;
                mmu_wdata = s1_wdata;
            end
            default: begin
                sel_req_s = 1'b0;
            end
        endcase
        mmu_req = sel_req_s & ~fifo_full_s;
    end

    // Handshake, exception and response steering back to the requesters.
    always_comb begin
        grant0_s   = mmu_req & (sel_s == PORT0);
        grant1_s   = mmu_req & (sel_s == PORT1);
        push_s     = mmu_req & mmu_addr_ok;
        pop_s      = mmu_data_ok & ~fifo_empty_s;
        s0_addr_ok = grant0_s & mmu_addr_ok;
        s1_addr_ok = grant1_s & mmu_addr_ok;
        s0_tlbr    = grant0_s & mmu_tlbr;
        s0_pil     = grant0_s & mmu_pil;
        s0_pis     = grant0_s & mmu_pis;
        s0_ppi     = grant0_s & mmu_ppi;
        s0_pme     = grant0_s & mmu_pme;
        s1_tlbr    = grant1_s & mmu_tlbr;
        s1_pil     = grant1_s & mmu_pil;
        s1_pis     = grant1_s & mmu_pis;
        s1_ppi     = grant1_s & mmu_ppi;
        s1_pme     = grant1_s & mmu_pme;
        s0_data_ok = pop_s & (head_s == PORT0);
        s1_data_ok = pop_s & (head_s == PORT1);
        s0_rdata   = mmu_rdata;
        s1_rdata   = mmu_rdata;
    end

    // Lock next-state: hold the grant while an issued request awaits addr_ok;
    // a handshake or a dropped request both release it.
    always_comb begin
        lock_valid_d = 1'b0;
        lock_port_d  = lock_port_q;
        if (mmu_req && !mmu_addr_ok) begin
            lock_valid_d = 1'b1;
            lock_port_d  = sel_s;
        end else begin
            lock_valid_d = 1'b0;
        end
    end

    // Lock register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_port_q  <= PORT0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_port_q  <= lock_port_d;
        end
    end

    order_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .push_id (sel_s),
        .pop     (pop_s),
        .head_id (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

endmodule : lsu_arbiter

// File: tb/tb_lsu_arbiter.sv
// Directed self-checking bench for lsu_arbiter: a table of single-cycle
// arbitration vectors plus hand-written multi-cycle sequences.
module tb_lsu_arbiter;

    localparam logic [31:0] ADDR0 = 32'hA000_0010;
    localparam logic [31:0] ADDR1 = 32'hB000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic [31:0] s0_addr = ADDR0, s1_addr = ADDR1;
    logic        s0_we = 1'b1, s1_we = 1'b0;
    logic [1:0]  s0_size = 2'd2, s1_size = 2'd1;
    logic [3:0]  s0_wstrb = 4'hF, s1_wstrb = 4'h3;
    logic [31:0] s0_wdata = 32'h1234_5678, s1_wdata = 32'h9ABC_DEF0;
    logic        s0_addr_ok, s1_addr_ok, s0_data_ok, s1_data_ok;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_tlbr, s0_pil, s0_pis, s0_ppi, s0_pme;
    logic        s1_tlbr, s1_pil, s1_pis, s1_ppi, s1_pme;
    logic        mmu_req, mmu_we;
    logic [31:0] mmu_addr, mmu_wdata;
    logic [1:0]  mmu_size;
    logic [3:0]  mmu_wstrb;
    logic        mmu_addr_ok = 1'b0, mmu_data_ok = 1'b0;
    logic [31:0] mmu_rdata = 32'h0;
    logic [4:0]  mexc = 5'b0;
    wire  [4:0]  s0_exc = {s0_tlbr, s0_pil, s0_pis, s0_ppi, s0_pme};
    wire  [4:0]  s1_exc = {s1_tlbr, s1_pil, s1_pis, s1_ppi, s1_pme};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_arbiter #(.OUTST_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .s0_req(s0_req), .s0_addr(s0_addr), .s0_we(s0_we), .s0_size(s0_size),
        .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata), .s0_addr_ok(s0_addr_ok),
        .s0_data_ok(s0_data_ok), .s0_rdata(s0_rdata),
        .s0_tlbr(s0_tlbr), .s0_pil(s0_pil), .s0_pis(s0_pis), .s0_ppi(s0_ppi), .s0_pme(s0_pme),
        .s1_req(s1_req), .s1_addr(s1_addr), .s1_we(s1_we), .s1_size(s1_size),
        .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata), .s1_addr_ok(s1_addr_ok),
        .s1_data_ok(s1_data_ok), .s1_rdata(s1_rdata),
        .s1_tlbr(s1_tlbr), .s1_pil(s1_pil), .s1_pis(s1_pis), .s1_ppi(s1_ppi), .s1_pme(s1_pme),
        .mmu_req(mmu_req), .mmu_addr(mmu_addr), .mmu_we(mmu_we), .mmu_size(mmu_size),
        .mmu_wstrb(mmu_wstrb), .mmu_wdata(mmu_wdata),
        .mmu_addr_ok(mmu_addr_ok), .mmu_data_ok(mmu_data_ok), .mmu_rdata(mmu_rdata),
        .mmu_tlbr(mexc[4]), .mmu_pil(mexc[3]), .mmu_pis(mexc[2]), .mmu_ppi(mexc[1]), .mmu_pme(mexc[0])
    );

    typedef struct {
        logic        s0r, s1r, aok;
        logic [4:0]  exc;
        logic        chk_addr;
        logic [31:0] addr;
        logic        mreq, a0, a1;
        logic [4:0]  e0, e1;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_req = 1'b0; s1_req = 1'b0;
        mmu_addr_ok = 1'b0; mmu_data_ok = 1'b0;
        mexc = 5'b0; mmu_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vt[1] = '{1'b1, 1'b0, 1'b1, 5'b00000, 1'b1, ADDR0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000};
        vt[2] = '{1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, ADDR1, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000};
        vt[3] = '{1'b1, 1'b1, 1'b1, 5'b00000, 1'b1, ADDR0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000};
        vt[4] = '{1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, ADDR0, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vt[5] = '{1'b0, 1'b1, 1'b0, 5'b10000, 1'b1, ADDR1, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b10000};
        vt[6] = '{1'b1, 1'b0, 1'b1, 5'b01010, 1'b1, ADDR0, 1'b1, 1'b1, 1'b0, 5'b01010, 5'b00000};
        vt[7] = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000};
        vt[8] = '{1'b1, 1'b1, 1'b0, 5'b00101, 1'b1, ADDR0, 1'b1, 1'b0, 1'b0, 5'b00101, 5'b00000};

        step(); step();
        reset = 1'b0;

        // Reset state, including a stray response with nothing outstanding.
        mmu_data_ok = 1'b1; mmu_rdata = 32'hDEAD_BEEF;
        #2;
        chk("rst_mmu_req", {31'b0, mmu_req}, 32'd0);
        chk("rst_addr_ok", {30'b0, s0_addr_ok, s1_addr_ok}, 32'd0);
        chk("rst_stray_data_ok", {30'b0, s0_data_ok, s1_data_ok}, 32'd0);

        // Single-cycle arbitration vectors, each from a fresh reset.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            s0_req = vt[i].s0r; s1_req = vt[i].s1r;
            mmu_addr_ok = vt[i].aok; mexc = vt[i].exc;
            #2;
            chk($sformatf("v%0d_mmu_req", i), {31'b0, mmu_req}, {31'b0, vt[i].mreq});
            chk($sformatf("v%0d_s0_addr_ok", i), {31'b0, s0_addr_ok}, {31'b0, vt[i].a0});
            chk($sformatf("v%0d_s1_addr_ok", i), {31'b0, s1_addr_ok}, {31'b0, vt[i].a1});
            chk($sformatf("v%0d_s0_exc", i), {27'b0, s0_exc}, {27'b0, vt[i].e0});
            chk($sformatf("v%0d_s1_exc", i), {27'b0, s1_exc}, {27'b0, vt[i].e1});
            if (vt[i].chk_addr) begin
                chk($sformatf("v%0d_mmu_addr", i), mmu_addr, vt[i].addr);
            end
        end

        // Both request with addr_ok: port 0 first, port 1 on the next cycle.
        do_reset();
        s0_req = 1'b1; s1_req = 1'b1; mmu_addr_ok = 1'b1;
        #2;
        chk("both_s0_ok", {31'b0, s0_addr_ok}, 32'd1);
        chk("both_s1_ok", {31'b0, s1_addr_ok}, 32'd0);
        chk("both_addr", mmu_addr, ADDR0);
        chk("both_we", {31'b0, mmu_we}, 32'd1);
        chk("both_wstrb", {28'b0, mmu_wstrb}, 32'hF);
        step();
        s0_req = 1'b0;
        #2;
        chk("next_s1_ok", {31'b0, s1_addr_ok}, 32'd1);
        chk("next_addr", mmu_addr, ADDR1);
        chk("next_size", {30'b0, mmu_size}, 32'd1);
        chk("next_wdata", mmu_wdata, 32'h9ABC_DEF0);

        // Grant stays with port 1 while addr_ok is withheld, even once port 0 asks.
        do_reset();
        s1_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) s0_req = 1'b1;
            #2;
            chk($sformatf("lock_c%0d_addr", c), mmu_addr, ADDR1);
            chk($sformatf("lock_c%0d_s0_ok", c), {31'b0, s0_addr_ok}, 32'd0);
            step();
        end
        mmu_addr_ok = 1'b1;
        #2;
        chk("lock_rel_addr", mmu_addr, ADDR1);
        chk("lock_rel_s1_ok", {31'b0, s1_addr_ok}, 32'd1);
        chk("lock_rel_s0_ok", {31'b0, s0_addr_ok}, 32'd0);
        step();
        s1_req = 1'b0;
        #2;
        chk("after_lock_addr", mmu_addr, ADDR0);
        chk("after_lock_s0_ok", {31'b0, s0_addr_ok}, 32'd1);

        // Cancel: locked port 1 drops its request, lock clears the next cycle.
        do_reset();
        s1_req = 1'b1;
        step();
        s1_req = 1'b0; s0_req = 1'b1;
        #2;
        chk("cancel_mmu_req", {31'b0, mmu_req}, 32'd0);
        step();
        #2;
        chk("cancel_next_req", {31'b0, mmu_req}, 32'd1);
        chk("cancel_next_addr", mmu_addr, ADDR0);

        // In-order responses after s0, s1, s0 accepts.
        do_reset();
        mmu_addr_ok = 1'b1;
        s0_req = 1'b1; step();
        s0_req = 1'b0; s1_req = 1'b1; step();
        s1_req = 1'b0; s0_req = 1'b1; step();
        idle_inputs();
        mmu_data_ok = 1'b1;
        for (int r = 0; r < 3; r++) begin
            mmu_rdata = (r == 0) ? 32'h11 : (r == 1) ? 32'h22 : 32'h33;
            #2;
            chk($sformatf("ord%0d_s0_data_ok", r), {31'b0, s0_data_ok}, (r == 1) ? 32'd0 : 32'd1);
            chk($sformatf("ord%0d_s1_data_ok", r), {31'b0, s1_data_ok}, (r == 1) ? 32'd1 : 32'd0);
            chk($sformatf("ord%0d_s0_rdata", r), s0_rdata, mmu_rdata);
            chk($sformatf("ord%0d_s1_rdata", r), s1_rdata, mmu_rdata);
            step();
        end
        #2;
        chk("empty_pop_ignored", {30'b0, s0_data_ok, s1_data_ok}, 32'd0);

        // Accept and response in the same cycle: s1 accepted, then s0 accepted
        // while s1's data returns, then s0's data.
        do_reset();
        s1_req = 1'b1; mmu_addr_ok = 1'b1;
        step();
        s1_req = 1'b0; s0_req = 1'b1; mmu_data_ok = 1'b1; mmu_rdata = 32'h44;
        #2;
        chk("ovl_s0_addr_ok", {31'b0, s0_addr_ok}, 32'd1);
        chk("ovl_s1_data_ok", {31'b0, s1_data_ok}, 32'd1);
        chk("ovl_s0_data_ok", {31'b0, s0_data_ok}, 32'd0);
        step();
        s0_req = 1'b0; mmu_addr_ok = 1'b0; mmu_rdata = 32'h55;
        #2;
        chk("ovl2_s0_data_ok", {31'b0, s0_data_ok}, 32'd1);
        chk("ovl2_s1_data_ok", {31'b0, s1_data_ok}, 32'd0);

        // Full order FIFO blocks further issue; one response frees a slot.
        do_reset();
        s0_req = 1'b1; mmu_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) step();
        #2;
        chk("full_mmu_req", {31'b0, mmu_req}, 32'd0);
        chk("full_s0_addr_ok", {31'b0, s0_addr_ok}, 32'd0);
        mmu_addr_ok = 1'b0; mmu_data_ok = 1'b1;
        #2;
        chk("full_pop_data_ok", {31'b0, s0_data_ok}, 32'd1);
        step();
        mmu_data_ok = 1'b0;
        #2;
        chk("after_pop_mmu_req", {31'b0, mmu_req}, 32'd1);

        // Reset with two outstanding discards them; a stray response is ignored.
        do_reset();
        s0_req = 1'b1; mmu_addr_ok = 1'b1; step();
        s0_req = 1'b0; s1_req = 1'b1; step();
        do_reset();
        mmu_data_ok = 1'b1; mmu_rdata = 32'h66;
        #2;
        chk("rst_out_s0_data_ok", {31'b0, s0_data_ok}, 32'd0);
        chk("rst_out_s1_data_ok", {31'b0, s1_data_ok}, 32'd0);
        chk("rst_out_mmu_req", {31'b0, mmu_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lsu_arbiter
